// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, widths and line/word helpers for the L1 data cache
package dcache_pkg;

  localparam int LINE_BYTES = 64;
  localparam int WORD_BITS  = 64;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int OFFSET_W   = 6;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_RESP
  } state_e;

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_sets);
    return addr_w - OFFSET_W - $clog2(num_sets);
  endfunction

  function automatic word_t get_word(input line_t line, input logic [2:0] sel);
    return line[{sel, 6'b0} +: WORD_BITS];
  endfunction

  function automatic line_t put_word(input line_t line, input logic [2:0] sel, input word_t w);
    line_t r;
    r = line;
    r[{sel, 6'b0} +: WORD_BITS] = w;
    return r;
  endfunction

endpackage

// File: rtl/data_cache_ctrl_if.sv
// rtl/data_cache_ctrl_if.sv - CPU request port and arbiter data port interfaces for the data cache
interface dcache_cpu_if #(
  parameter int ADDR_W = 64
) ();
  logic              enable;
  logic              wenable;
  logic              clflush;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata;
  logic [63:0]       rdata;
  logic              done;

  modport master (output enable, wenable, clflush, addr, wdata, input rdata, done);
  modport slave  (input enable, wenable, clflush, addr, wdata, output rdata, done);
endinterface

interface dcache_mem_if #(
  parameter int ADDR_W = 64
) ();
  logic              drequest;
  logic              dreqack;
  logic              dwrenable;
  logic [ADDR_W-1:0] daddr;
  logic [511:0]      drdata;
  logic [511:0]      dwdata;
  logic              ddone;

  modport master (output drequest, dwrenable, daddr, dwdata, input dreqack, drdata, ddone);
  modport slave  (input drequest, dwrenable, daddr, dwdata, output dreqack, drdata, ddone);
endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/dirty/data storage, one combinational read port and one write port
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int IDX_W    = 6,
  parameter int TAG_W    = 52
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TAG_W-1:0] rd_tag,
  output line_t            rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic             wr_valid,
  input  logic             wr_dirty,
  input  logic [TAG_W-1:0] wr_tag,
  input  line_t            wr_data
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  line_t               data_mem [NUM_SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      valid_d[wr_index] = wr_valid;
      dirty_d[wr_index] = wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Payload storage is not reset; valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache_ctrl.sv
// rtl/data_cache_ctrl.sv - direct-mapped write-back L1 data cache controller
// Optional hit/miss counters enabled by defining DCACHE_STATS_EN.
module data_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int ADDR_W   = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  dcache_cpu_if.slave cpu,
  dcache_mem_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = index_w(NUM_SETS);
  localparam int TAG_W = tag_w(ADDR_W, NUM_SETS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:3] addr_q, addr_d;
  word_t             wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic              flush_q, flush_d;
  word_t             rdata_q, rdata_d;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       word_sel;
  logic             hit;
  logic             wb_fin;
  logic             fill_fin;

  logic             rd_valid, rd_dirty;
  logic [TAG_W-1:0] rd_tag;
  line_t            rd_data;
  logic             arr_we, arr_wr_valid, arr_wr_dirty;
  logic [TAG_W-1:0] arr_wr_tag;
  line_t            arr_wr_data;

  logic              drequest, dwrenable;
  logic [ADDR_W-1:0] daddr;
  line_t             dwdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu.addr[2:0];

  assign req_idx  = addr_q[OFFSET_W+IDX_W-1:OFFSET_W];
  assign req_tag  = addr_q[ADDR_W-1:OFFSET_W+IDX_W];
  assign word_sel = addr_q[5:3];
  assign hit      = rd_valid && (rd_tag == req_tag);

  dcache_array #(
    .NUM_SETS(NUM_SETS),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_index(req_idx),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (arr_we),
    .wr_index(req_idx),
    .wr_valid(arr_wr_valid),
    .wr_dirty(arr_wr_dirty),
    .wr_tag  (arr_wr_tag),
    .wr_data (arr_wr_data)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wen_d        = wen_q;
    flush_d      = flush_q;
    rdata_d      = rdata_q;
    arr_we       = 1'b0;
    arr_wr_valid = rd_valid;
    arr_wr_dirty = rd_dirty;
    arr_wr_tag   = rd_tag;
    arr_wr_data  = rd_data;
    drequest     = 1'b0;
    dwrenable    = 1'b0;
    daddr        = '0;
    dwdata       = '0;
    wb_fin       = 1'b0;
    fill_fin     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu.enable) begin
          addr_d  = cpu.addr[ADDR_W-1:3];
          wdata_d = cpu.wdata;
          wen_d   = cpu.wenable && !cpu.clflush;
          flush_d = cpu.clflush;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (flush_q) begin
          if (hit && rd_dirty) begin
            state_d = ST_WB_REQ;
          end else begin
            arr_we       = hit;
            arr_wr_valid = 1'b0;
            arr_wr_dirty = 1'b0;
            rdata_d      = '0;
            state_d      = ST_RESP;
          end
        end else if (hit) begin
          if (wen_q) begin
            arr_we       = 1'b1;
            arr_wr_dirty = 1'b1;
            arr_wr_data  = put_word(rd_data, word_sel, wdata_q);
            rdata_d      = '0;
          end else begin
            rdata_d = get_word(rd_data, word_sel);
          end
          state_d = ST_RESP;
        end else if (rd_valid && rd_dirty) begin
          state_d = ST_WB_REQ;
        end else begin
          state_d = ST_FILL_REQ;
        end
      end
      ST_WB_REQ: begin
        drequest  = 1'b1;
        dwrenable = 1'b1;
        daddr     = {rd_tag, req_idx, 6'b0};
        dwdata    = rd_data;
        if (mem.dreqack) begin
          if (mem.ddone) wb_fin = 1'b1;
          else           state_d = ST_WB_WAIT;
        end
      end
      ST_WB_WAIT: begin
        dwrenable = 1'b1;
        daddr     = {rd_tag, req_idx, 6'b0};
        dwdata    = rd_data;
        if (mem.ddone) wb_fin = 1'b1;
      end
      ST_FILL_REQ: begin
        drequest = 1'b1;
        daddr    = {req_tag, req_idx, 6'b0};
        if (mem.dreqack) begin
          if (mem.ddone) fill_fin = 1'b1;
          else           state_d = ST_FILL_WAIT;
        end
      end
      ST_FILL_WAIT: begin
        daddr = {req_tag, req_idx, 6'b0};
        if (mem.ddone) fill_fin = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A finished write-back either ends a flush or frees the set for refill.
    if (wb_fin) begin
      arr_we       = 1'b1;
      arr_wr_dirty = 1'b0;
      if (flush_q) begin
        arr_wr_valid = 1'b0;
        rdata_d      = '0;
        state_d      = ST_RESP;
      end else begin
        state_d = ST_FILL_REQ;
      end
    end

    if (fill_fin) begin
      arr_we       = 1'b1;
      arr_wr_valid = 1'b1;
      arr_wr_tag   = req_tag;
      if (wen_q) begin
        arr_wr_data  = put_word(mem.drdata, word_sel, wdata_q);
        arr_wr_dirty = 1'b1;
        rdata_d      = '0;
      end else begin
        arr_wr_data  = mem.drdata;
        arr_wr_dirty = 1'b0;
        rdata_d      = get_word(mem.drdata, word_sel);
      end
      state_d = ST_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      flush_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      flush_q <= flush_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu.rdata     = rdata_q;
  assign cpu.done      = (state_q == ST_RESP);
  assign mem.drequest  = drequest;
  assign mem.dwrenable = dwrenable;
  assign mem.daddr     = daddr;
  assign mem.dwdata    = dwdata;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_LOOKUP && !flush_q) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb/tb_data_cache_ctrl.sv - directed table-driven bench for data_cache_ctrl with an arbiter/memory model
module tb_data_cache_ctrl;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dcache_cpu_if #(.ADDR_W(64)) cpu ();
  dcache_mem_if #(.ADDR_W(64)) mem ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache_ctrl #(.NUM_SETS(64), .ADDR_W(64)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .cpu    (cpu),
    .mem    (mem)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  typedef struct {
    bit          wen;
    bit          fl;
    bit          sc;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    bit          exp_wb;
    logic [63:0] exp_wb_addr;
    logic [2:0]  wb_word;
    logic [63:0] exp_wb_word;
    bit          exp_fill;
    logic [63:0] exp_fill_addr;
  } vec_t;

  vec_t vecs[16];

  int checks = 0;
  int passed = 0;

  line_t       mem_lines [logic [63:0]];
  bit          same_cycle;
  int          arb_cnt;
  bit          arb_wr;
  logic [63:0] arb_addr;
  bit          wb_seen, fill_seen, timed_out;
  logic [63:0] wb_addr, fill_addr, got_rdata;
  line_t       wb_line;
  int          latency, done_pulses;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic line_t mem_read(input logic [63:0] la);
    line_t l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = la + 64'(i * 8);
    return l;
  endfunction

  function automatic vec_t mk(input bit wen, input bit fl, input bit sc, input logic [63:0] a,
                              input logic [63:0] wd, input logic [63:0] er, input bit ewb,
                              input logic [63:0] ewa, input logic [2:0] ww, input logic [63:0] ewd,
                              input bit ef, input logic [63:0] efa);
    vec_t v;
    v.wen = wen; v.fl = fl; v.sc = sc; v.addr = a; v.wdata = wd; v.exp_rdata = er;
    v.exp_wb = ewb; v.exp_wb_addr = ewa; v.wb_word = ww; v.exp_wb_word = ewd;
    v.exp_fill = ef; v.exp_fill_addr = efa;
    return v;
  endfunction

  // Arbiter: acks a request on the next edge, completes two cycles later (or at once in same-cycle mode).
  task automatic arb_step();
    mem.dreqack = 1'b0;
    mem.ddone   = 1'b0;
    if (arb_cnt > 0) begin
      arb_cnt--;
      if (arb_cnt == 0) begin
        mem.ddone = 1'b1;
        if (!arb_wr) mem.drdata = mem_read(arb_addr);
      end
    end else if (mem.drequest) begin
      mem.dreqack = 1'b1;
      arb_addr    = mem.daddr;
      arb_wr      = mem.dwrenable;
      if (arb_wr) begin
        wb_seen = 1'b1;
        wb_addr = mem.daddr;
        wb_line = mem.dwdata;
        mem_lines[mem.daddr] = mem.dwdata;
      end else begin
        fill_seen = 1'b1;
        fill_addr = mem.daddr;
      end
      if (same_cycle) begin
        mem.ddone = 1'b1;
        if (!arb_wr) mem.drdata = mem_read(arb_addr);
      end else begin
        arb_cnt = 2;
      end
    end
  endtask

  task automatic run_access(input bit wen, input bit fl, input logic [63:0] a, input logic [63:0] wd);
    int cyc;
    bit fin;
    wb_seen = 0; fill_seen = 0; timed_out = 0; wb_addr = '0; fill_addr = '0;
    wb_line = '0; got_rdata = '0; latency = 0; done_pulses = 0; arb_cnt = 0;
    cyc = 0; fin = 0;
    @(negedge clk);
    cpu.enable = 1'b1; cpu.wenable = wen; cpu.clflush = fl; cpu.addr = a; cpu.wdata = wd;
    while (!fin && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu.done) begin
        fin = 1; latency = cyc; got_rdata = cpu.rdata; done_pulses++;
        cpu.enable = 1'b0;
      end
      arb_step();
    end
    if (!fin) timed_out = 1;
    cpu.enable = 1'b0;
    mem.dreqack = 1'b0;
    mem.ddone = 1'b0;
    @(posedge clk); #1;
    if (cpu.done) done_pulses++;
  endtask

  task automatic apply_vec(input string nm, input vec_t v);
    same_cycle = v.sc;
    run_access(v.wen, v.fl, v.addr, v.wdata);
    check64({nm, " timeout"}, 64'(timed_out), 64'd0);
    check64({nm, " done_pulses"}, 64'(done_pulses), 64'd1);
    if (!v.wen || v.fl) check64({nm, " rdata"}, got_rdata, v.exp_rdata);
    check64({nm, " wb_seen"}, 64'(wb_seen), 64'(v.exp_wb));
    if (v.exp_wb) begin
      check64({nm, " wb_addr"}, wb_addr, v.exp_wb_addr);
      check64({nm, " wb_word"}, wb_line[{v.wb_word, 6'b0} +: 64], v.exp_wb_word);
    end
    check64({nm, " fill_seen"}, 64'(fill_seen), 64'(v.exp_fill));
    if (v.exp_fill) check64({nm, " fill_addr"}, fill_addr, v.exp_fill_addr);
    if (!v.exp_wb && !v.exp_fill) check64({nm, " latency"}, 64'(latency), 64'd2);
  endtask

  initial begin
    line_t seed;
    int cyc;
    bit got;

    cpu.enable = 0; cpu.wenable = 0; cpu.clflush = 0; cpu.addr = '0; cpu.wdata = '0;
    mem.dreqack = 0; mem.ddone = 0; mem.drdata = '0;
    same_cycle = 0; arb_cnt = 0; arb_wr = 0; arb_addr = '0;

    seed = mem_read(64'h1000);
    seed[127:64] = 64'h0000_0000_DEAD_BEEF;
    mem_lines[64'h1000] = seed;

    //          wen fl sc addr                    wdata  exp_rdata            wb wb_addr                 w  wb_word  fill fill_addr
    vecs[0]  = mk(0, 0, 0, 64'h1008,               0,     64'hDEAD_BEEF,       0, 0,                      0, 0,       1, 64'h1000);
    vecs[1]  = mk(1, 0, 0, 64'h1010,               64'h55, 0,                  0, 0,                      0, 0,       0, 0);
    vecs[2]  = mk(0, 0, 0, 64'h1010,               0,     64'h55,              0, 0,                      0, 0,       0, 0);
    vecs[3]  = mk(0, 0, 1, 64'h2010,               0,     64'h2010,            1, 64'h1000,               2, 64'h55,  1, 64'h2000);
    vecs[4]  = mk(0, 1, 0, 64'h2000,               0,     0,                   0, 0,                      0, 0,       0, 0);
    vecs[5]  = mk(0, 0, 0, 64'h2000,               0,     64'h2000,            0, 0,                      0, 0,       1, 64'h2000);
    vecs[6]  = mk(1, 0, 0, 64'h3018,               64'h7, 0,                   0, 0,                      0, 0,       1, 64'h3000);
    vecs[7]  = mk(0, 0, 0, 64'h1008,               0,     64'hDEAD_BEEF,       1, 64'h3000,               3, 64'h7,   1, 64'h1000);
    vecs[8]  = mk(1, 1, 0, 64'h1010,               64'h99, 0,                  0, 0,                      0, 0,       0, 0);
    vecs[9]  = mk(0, 0, 0, 64'h1010,               0,     64'h55,              0, 0,                      0, 0,       1, 64'h1000);
    vecs[10] = mk(1, 0, 1, 64'h1040,               64'hAB, 0,                  0, 0,                      0, 0,       1, 64'h1040);
    vecs[11] = mk(0, 1, 0, 64'h1040,               0,     0,                   1, 64'h1040,               0, 64'hAB,  0, 0);
    vecs[12] = mk(0, 1, 0, 64'h5000,               0,     0,                   0, 0,                      0, 0,       0, 0);
    vecs[13] = mk(0, 0, 0, 64'h1040,               0,     64'hAB,              0, 0,                      0, 0,       1, 64'h1040);
    vecs[14] = mk(1, 0, 0, 64'h8000_0000_0000_1008, 64'h1234, 0,               0, 0,                      0, 0,       1, 64'h8000_0000_0000_1000);
    vecs[15] = mk(0, 0, 1, 64'h1008,               0,     64'hDEAD_BEEF,       1, 64'h8000_0000_0000_1000, 1, 64'h1234, 1, 64'h1000);

    repeat (3) @(posedge clk);
    #1;
    check64("reset done", 64'(cpu.done), 64'd0);
    check64("reset drequest", 64'(mem.drequest), 64'd0);
    check64("reset dwrenable", 64'(mem.dwrenable), 64'd0);
    check64("reset daddr", mem.daddr, 64'd0);
    check64("reset dwdata", 64'(mem.dwdata != '0), 64'd0);
    check64("reset rdata", cpu.rdata, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) apply_vec($sformatf("v%0d", i), vecs[i]);

    // Reset while a refill is outstanding.
    same_cycle = 0;
    @(negedge clk);
    cpu.enable = 1; cpu.wenable = 0; cpu.clflush = 0; cpu.addr = 64'h6008;
    got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (mem.drequest) begin
        got = 1;
        mem.dreqack = 1'b1;
      end
    end
    check64("rst fill requested", 64'(got), 64'd1);
    check64("rst fill addr", mem.daddr, 64'h6000);
    @(posedge clk); #1;
    mem.dreqack = 1'b0;
    check64("rst wait drequest", 64'(mem.drequest), 64'd0);
    @(negedge clk);
    reset_n = 1'b0;
    cpu.enable = 0;
    @(posedge clk); #1;
    check64("rst drequest", 64'(mem.drequest), 64'd0);
    check64("rst done", 64'(cpu.done), 64'd0);
    check64("rst daddr", mem.daddr, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mem.ddone = 1'b1;
    mem.drdata = '1;
    @(posedge clk); #1;
    mem.ddone = 1'b0;
    check64("stray ddone done", 64'(cpu.done), 64'd0);
    check64("stray ddone drequest", 64'(mem.drequest), 64'd0);
    @(posedge clk); #1;
    check64("stray ddone done2", 64'(cpu.done), 64'd0);

    apply_vec("post_rst0", mk(0, 0, 0, 64'h1008, 0, 64'hDEAD_BEEF, 0, 0, 0, 0, 1, 64'h1000));
    apply_vec("post_rst1", mk(0, 0, 0, 64'h1040, 0, 64'hAB, 0, 0, 0, 0, 1, 64'h1040));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
